// File: rtl/int_issue_queue.sv
// Age-ordered integer reservation station: entries shift toward index 0 on issue,
// operands wake up from the CDB, and the oldest ready entry drives the ALU port.
module int_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_int_dispatch,
    input  logic [31:0] disp_rs1_data,
    input  logic [31:0] disp_rs2_data,
    input  logic        disp_rs1_data_valid,
    input  logic        disp_rs2_data_valid,
    input  logic [5:0]  disp_rs1_tag,
    input  logic [5:0]  disp_rs2_tag,
    input  logic [5:0]  disp_rd_tag,
    input  logic [6:0]  disp_opcode,
    input  logic [2:0]  disp_func3,
    input  logic [6:0]  disp_func7,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    input  logic        flush,
    input  logic        issue_ready,
    output logic        issue_valid,
    output logic [31:0] issue_rs1_data,
    output logic [31:0] issue_rs2_data,
    output logic [5:0]  issue_rd_tag,
    output logic [6:0]  issue_opcode,
    output logic [2:0]  issue_func3,
    output logic [6:0]  issue_func7,
    output logic        queue_full,
    output logic        queue_empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic        vld;
        logic [31:0] rs1_data;
        logic        rs1_valid;
        logic [5:0]  rs1_tag;
        logic [31:0] rs2_data;
        logic        rs2_valid;
        logic [5:0]  rs2_tag;
        logic [5:0]  rd_tag;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
    } entry_t;

    entry_t          entry_reg [DEPTH];
    entry_t          entry_next[DEPTH];
    entry_t          shifted   [DEPTH];
    entry_t          incoming;
    entry_t          sel_entry;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   count_after;
    logic [DEPTH-1:0] ready;
    logic [IW-1:0]   sel_idx;
    logic            issue_fire;
    logic            do_enq;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ready
            assign ready[gi] = entry_reg[gi].vld && entry_reg[gi].rs1_valid && entry_reg[gi].rs2_valid;
        end
    endgenerate

    // Reverse scan so the lowest (oldest) ready index wins.
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) sel_idx = IW'(i);
        end
    end

    assign issue_valid = |ready;
    assign issue_fire  = issue_valid && issue_ready;
    assign sel_entry   = entry_reg[sel_idx];

    assign issue_rs1_data = issue_valid ? sel_entry.rs1_data : '0;
    assign issue_rs2_data = issue_valid ? sel_entry.rs2_data : '0;
    assign issue_rd_tag   = issue_valid ? sel_entry.rd_tag   : '0;
    assign issue_opcode   = issue_valid ? sel_entry.opcode   : '0;
    assign issue_func3    = issue_valid ? sel_entry.func3    : '0;
    assign issue_func7    = issue_valid ? sel_entry.func7    : '0;

    assign queue_full  = (count_reg == CW'(DEPTH));
    assign queue_empty = (count_reg == '0);

    // Dispatched operands capture a same-cycle CDB broadcast on the way in.
    always_comb begin
        incoming.vld       = 1'b1;
        incoming.rs1_data  = disp_rs1_data;
        incoming.rs1_valid = disp_rs1_data_valid;
        incoming.rs1_tag   = disp_rs1_tag;
        incoming.rs2_data  = disp_rs2_data;
        incoming.rs2_valid = disp_rs2_data_valid;
        incoming.rs2_tag   = disp_rs2_tag;
        incoming.rd_tag    = disp_rd_tag;
        incoming.opcode    = disp_opcode;
        incoming.func3     = disp_func3;
        incoming.func7     = disp_func7;
        if (cdb_valid && !disp_rs1_data_valid && disp_rs1_tag == cdb_tag) begin
            incoming.rs1_data  = cdb_data;
            incoming.rs1_valid = 1'b1;
        end
        if (cdb_valid && !disp_rs2_data_valid && disp_rs2_tag == cdb_tag) begin
            incoming.rs2_data  = cdb_data;
            incoming.rs2_valid = 1'b1;
        end
    end

    // Shift first, then wake up, then append: a moving entry keeps its CDB capture.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) shifted[i] = entry_reg[i];
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (issue_fire && IW'(i) >= sel_idx) shifted[i] = entry_reg[i + 1];
        end
        if (issue_fire) shifted[DEPTH - 1] = '0;

        count_after = count_reg - CW'(issue_fire);
        do_enq      = en_int_dispatch && !queue_full;
        count_next  = count_after + CW'(do_enq);

        for (int i = 0; i < DEPTH; i++) begin
            entry_next[i] = shifted[i];
            if (shifted[i].vld && cdb_valid && !shifted[i].rs1_valid && shifted[i].rs1_tag == cdb_tag) begin
                entry_next[i].rs1_data  = cdb_data;
                entry_next[i].rs1_valid = 1'b1;
            end
            if (shifted[i].vld && cdb_valid && !shifted[i].rs2_valid && shifted[i].rs2_tag == cdb_tag) begin
                entry_next[i].rs2_data  = cdb_data;
                entry_next[i].rs2_valid = 1'b1;
            end
            if (do_enq && count_after == CW'(i)) entry_next[i] = incoming;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed plus randomized bench for int_issue_queue against a queue-based age-ordered model.
module tb_int_issue_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, en_int_dispatch, flush, issue_ready, cdb_valid;
    logic [31:0] disp_rs1_data, disp_rs2_data, cdb_data;
    logic        disp_rs1_data_valid, disp_rs2_data_valid;
    logic [5:0]  disp_rs1_tag, disp_rs2_tag, disp_rd_tag, cdb_tag;
    logic [6:0]  disp_opcode, disp_func7;
    logic [2:0]  disp_func3;
    logic        issue_valid, queue_full, queue_empty;
    logic [31:0] issue_rs1_data, issue_rs2_data;
    logic [5:0]  issue_rd_tag;
    logic [6:0]  issue_opcode, issue_func7;
    logic [2:0]  issue_func3;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d1, d2;
        logic        v1, v2;
        logic [5:0]  t1, t2, rd;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
    } m_t;
    m_t m_q[$];

    int_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en_int_dispatch(en_int_dispatch),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .disp_rs1_data_valid(disp_rs1_data_valid), .disp_rs2_data_valid(disp_rs2_data_valid),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag), .disp_rd_tag(disp_rd_tag),
        .disp_opcode(disp_opcode), .disp_func3(disp_func3), .disp_func7(disp_func7),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .issue_ready(issue_ready),
        .issue_valid(issue_valid), .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_rd_tag(issue_rd_tag), .issue_opcode(issue_opcode), .issue_func3(issue_func3),
        .issue_func7(issue_func7), .queue_full(queue_full), .queue_empty(queue_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int find_ready();
        for (int i = 0; i < m_q.size(); i++)
            if (m_q[i].v1 && m_q[i].v2) return i;
        return -1;
    endfunction

    task automatic check_outputs();
        int idx;
        idx = find_ready();
        chk("issue_valid", issue_valid, (idx >= 0));
        chk("queue_full",  queue_full,  (m_q.size() == DEPTH));
        chk("queue_empty", queue_empty, (m_q.size() == 0));
        if (idx >= 0) begin
            chk("issue_rs1_data", issue_rs1_data, m_q[idx].d1);
            chk("issue_rs2_data", issue_rs2_data, m_q[idx].d2);
            chk("issue_rd_tag",   issue_rd_tag,   m_q[idx].rd);
            chk("issue_opcode",   issue_opcode,   m_q[idx].op);
            chk("issue_func3",    issue_func3,    m_q[idx].f3);
            chk("issue_func7",    issue_func7,    m_q[idx].f7);
        end
    endtask

    task automatic model_edge();
        int idx;
        bit was_full;
        m_t e;
        idx = find_ready();
        was_full = (m_q.size() == DEPTH);
        if (rst || flush) begin
            m_q.delete();
        end else begin
            if (idx >= 0 && issue_ready) m_q.delete(idx);
            foreach (m_q[i]) begin
                if (cdb_valid && !m_q[i].v1 && m_q[i].t1 == cdb_tag) begin m_q[i].d1 = cdb_data; m_q[i].v1 = 1'b1; end
                if (cdb_valid && !m_q[i].v2 && m_q[i].t2 == cdb_tag) begin m_q[i].d2 = cdb_data; m_q[i].v2 = 1'b1; end
            end
            if (en_int_dispatch && !was_full) begin
                e.d1 = disp_rs1_data; e.v1 = disp_rs1_data_valid; e.t1 = disp_rs1_tag;
                e.d2 = disp_rs2_data; e.v2 = disp_rs2_data_valid; e.t2 = disp_rs2_tag;
                e.rd = disp_rd_tag; e.op = disp_opcode; e.f3 = disp_func3; e.f7 = disp_func7;
                if (cdb_valid && !e.v1 && e.t1 == cdb_tag) begin e.d1 = cdb_data; e.v1 = 1'b1; end
                if (cdb_valid && !e.v2 && e.t2 == cdb_tag) begin e.d2 = cdb_data; e.v2 = 1'b1; end
                m_q.push_back(e);
            end
        end
    endtask

    // One clock: check pre-edge outputs, advance model at the edge, settle.
    task automatic cycle();
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_disp(input logic [31:0] r1, input logic v1, input logic [5:0] t1,
                            input logic [31:0] r2, input logic v2, input logic [5:0] t2,
                            input logic [5:0] rd);
        en_int_dispatch = 1'b1;
        disp_rs1_data = r1; disp_rs1_data_valid = v1; disp_rs1_tag = t1;
        disp_rs2_data = r2; disp_rs2_data_valid = v2; disp_rs2_tag = t2;
        disp_rd_tag = rd; disp_opcode = 7'h33; disp_func3 = 3'd0; disp_func7 = 7'h00;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; en_int_dispatch = 1'b0; cdb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; en_int_dispatch = 1'b0; cdb_valid = 1'b0; issue_ready = 1'b0;
        disp_rs1_data = '0; disp_rs2_data = '0; disp_rs1_data_valid = 1'b0; disp_rs2_data_valid = 1'b0;
        disp_rs1_tag = '0; disp_rs2_tag = '0; disp_rd_tag = '0;
        disp_opcode = '0; disp_func3 = '0; disp_func7 = '0; cdb_tag = '0; cdb_data = '0;
        #2;
        @(posedge clk); model_edge(); #1;
        cycle();
        idle();
        chk("rst_issue_valid", issue_valid, 1'b0);
        chk("rst_empty", queue_empty, 1'b1);
        chk("rst_full", queue_full, 1'b0);
        chk("rst_rs1_zero", issue_rs1_data, 32'h0);

        // ADD with both operands ready issues the cycle after dispatch
        issue_ready = 1'b1;
        set_disp(32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd3);
        cycle(); idle();
        chk("add_valid", issue_valid, 1'b1);
        chk("add_rs1", issue_rs1_data, 32'd5);
        chk("add_rs2", issue_rs2_data, 32'd7);
        chk("add_rd", issue_rd_tag, 6'd3);
        cycle();
        chk("add_drained", queue_empty, 1'b1);

        // CDB wakeup of rs1 two cycles after dispatch
        set_disp(32'd0, 1'b0, 6'd9, 32'd1, 1'b1, 6'd0, 6'd4);
        cycle(); idle();
        cycle();
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h1234;
        cycle(); idle();
        chk("wake_valid", issue_valid, 1'b1);
        chk("wake_rs1", issue_rs1_data, 32'h1234);
        cycle();

        // Fill to DEPTH, overflow dispatch dropped, release one
        issue_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_disp(32'(i), 1'b1, 6'd0, 32'(i + 100), 1'b1, 6'd0, 6'(10 + i));
            cycle();
        end
        chk("fill_full", queue_full, 1'b1);
        set_disp(32'hDEAD, 1'b1, 6'd0, 32'hBEEF, 1'b1, 6'd0, 6'd14);
        cycle(); idle();
        chk("overflow_full", queue_full, 1'b1);
        chk("overflow_head", issue_rd_tag, 6'd10);
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        chk("release_full", queue_full, 1'b0);
        chk("release_head", issue_rd_tag, 6'd11);
        flush = 1'b1;
        cycle(); idle();

        // Younger ready entry bypasses an older blocked one
        set_disp(32'd0, 1'b0, 6'd4, 32'd2, 1'b1, 6'd0, 6'd20);
        cycle();
        set_disp(32'd8, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 6'd21);
        cycle(); idle();
        chk("ooo_first", issue_rd_tag, 6'd21);
        issue_ready = 1'b1;
        cycle();
        chk("ooo_blocked", issue_valid, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h44;
        cycle(); idle();
        chk("ooo_second", issue_rd_tag, 6'd20);
        chk("ooo_second_rs1", issue_rs1_data, 32'h44);
        cycle();

        // Dispatch capturing a same-cycle broadcast
        set_disp(32'd3, 1'b1, 6'd0, 32'd0, 1'b0, 6'd12, 6'd22);
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hAA;
        cycle(); idle();
        chk("bypass_valid", issue_valid, 1'b1);
        chk("bypass_rs2", issue_rs2_data, 32'hAA);
        cycle();

        // Flush overrides a same-cycle dispatch
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(32'd0, 1'b0, 6'd30, 32'd0, 1'b0, 6'd31, 6'(40 + i));
            cycle();
        end
        flush = 1'b1;
        set_disp(32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd45);
        cycle(); idle();
        chk("flush_empty", queue_empty, 1'b1);
        chk("flush_valid", issue_valid, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            en_int_dispatch     = ($urandom_range(0, 9) < 6);
            disp_rs1_data       = $urandom;
            disp_rs2_data       = $urandom;
            disp_rs1_data_valid = $urandom_range(0, 1) == 1;
            disp_rs2_data_valid = $urandom_range(0, 1) == 1;
            disp_rs1_tag        = 6'($urandom_range(0, 15));
            disp_rs2_tag        = 6'($urandom_range(0, 15));
            disp_rd_tag         = 6'($urandom_range(0, 63));
            disp_opcode         = 7'($urandom);
            disp_func3          = 3'($urandom);
            disp_func7          = 7'($urandom);
            cdb_valid           = ($urandom_range(0, 9) < 4);
            cdb_tag             = 6'($urandom_range(0, 15));
            cdb_data            = $urandom;
            issue_ready         = $urandom_range(0, 1) == 1;
            flush               = ($urandom_range(0, 99) < 3);
            rst                 = ($urandom_range(0, 99) < 1);
            cycle();
        end
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/int_issue_queue.md
INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of reservation entries (2..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: en_int_dispatch  input  1  dispatch write strobe for an integer instruction.
REQ-005 Port: disp_rs1_data, disp_rs2_data  input  32 each  operand values (rs2 = Imm for I-type/LUI).
REQ-006 Port: disp_rs1_data_valid, disp_rs2_data_valid  input  1 each  operand already resolved.
REQ-007 Port: disp_rs1_tag, disp_rs2_tag, disp_rd_tag  input  6 each  producer tags and destination tag.
REQ-008 Port: disp_opcode  input  7; disp_func3  input  3; disp_func7  input  7  decoded fields.
REQ-009 Port: cdb_valid  input  1; cdb_tag  input  6; cdb_data  input  32  common data bus broadcast.
REQ-010 Port: flush  input  1  branch-mispredict flush.
REQ-011 Port: issue_ready  input  1  integer ALU accepts an instruction this cycle.
REQ-012 Port: issue_valid  output  1; issue_rs1_data, issue_rs2_data  output  32; issue_rd_tag  output  6; issue_opcode  output  7; issue_func3  output  3; issue_func7  output  7.
REQ-013 Port: queue_full  output  1  no free entry (dispatch must stall); queue_empty  output  1.

Function
REQ-014 Storage SHALL be a shifting, age-ordered array: entry 0 oldest; valid entries always contiguous from index 0; count register 0..DEPTH.
REQ-015 Enqueue SHALL occur when en_int_dispatch=1 and queue_full=0; the new entry is written at index count (after any same-cycle shift from issue).
REQ-016 en_int_dispatch while queue_full=1 SHALL be ignored (no state change, no overwrite).
REQ-017 An entry is ready when both operand valid bits are 1; issue_valid SHALL be 1 iff at least one valid entry is ready.
REQ-018 Issue outputs SHALL be combinational from the oldest (lowest index) ready entry; no speculative bypass of same-cycle CDB or dispatch into selection.
REQ-019 Issue handshake: on issue_valid=1 and issue_ready=1 at a clock edge, the selected entry SHALL be removed and all younger entries shift down one index.
REQ-020 issue_valid=1 with issue_ready=0 SHALL hold the same selection stable unless an older entry becomes ready.
REQ-021 Wakeup: for each valid entry with operand valid=0 and tag equal to cdb_tag while cdb_valid=1, that operand's data SHALL load cdb_data and valid SHALL set at the edge; rs1 and rs2 checked independently.
REQ-022 Dispatch/CDB same cycle: if an incoming operand is invalid and its tag matches a valid CDB broadcast, it SHALL be written already valid with cdb_data.
REQ-023 Latency: an enqueued entry with both operands valid SHALL reach issue_valid the cycle after the write edge; a CDB wakeup likewise one cycle after broadcast.
REQ-024 Simultaneous issue and enqueue when count=DEPTH-1 or lower SHALL both take effect; count unchanged when one enters and one leaves.
REQ-025 queue_full SHALL equal (count==DEPTH); queue_empty SHALL equal (count==0); both registered-state derived, not dependent on same-cycle issue.
REQ-026 flush=1 SHALL clear all valid bits and set count=0 at the edge, overriding same-cycle enqueue and issue removal; issue_valid still reflects pre-flush state that cycle.
REQ-027 Wakeup SHALL apply to the entry value after shifting, so a shifting entry never loses a same-cycle CDB capture.

Reset
REQ-028 rst=1 SHALL at the edge set count=0, all entry valid and operand-valid bits 0; outputs then: issue_valid=0, queue_empty=1, queue_full=0; data fields undefined-free (driven 0).
REQ-029 rst SHALL take priority over flush, dispatch, issue and CDB; reset mid-operation discards all entries.

Verification
REQ-030 Dispatch ADD rs1=5 valid, rs2=7 valid, rd_tag=3, issue_ready=1 -> next cycle issue_valid=1, rs1=5, rs2=7, rd_tag=3; following cycle queue_empty=1.
REQ-031 Dispatch entry rs1 tag=9 invalid; after 2 cycles cdb_valid=1 tag=9 data=0x1234 -> next cycle issue_valid=1, issue_rs1_data=0x1234.
REQ-032 Fill 4 entries (DEPTH=4) with issue_ready=0 -> queue_full=1; fifth dispatch ignored; release one -> remaining order preserved, full deasserts.
REQ-033 Entry0 waits on tag 4, entry1 ready -> entry1 issues first; CDB tag 4 -> entry0 issues next.
REQ-034 Dispatch with rs2 tag=12 invalid while cdb_valid=1 tag=12 data=0xAA same cycle -> entry written valid, issues next cycle with rs2=0xAA.
REQ-035 Three entries queued, flush=1 with en_int_dispatch=1 -> next cycle count=0, queue_empty=1, issue_valid=0.
